// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - CPU data SRAM responder: word RAM plus LED/switch/timer/IRQ MMIO window
module data_sram_responder #(
   parameter int          AW        = 12,
   parameter logic [15:0] MMIO_BASE = 16'hbfaf
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        sram_en,
   input  logic [3:0]  sram_we,
   input  logic [31:0] sram_addr,
   input  logic [31:0] sram_wdata,
   output logic [31:0] sram_rdata,
   input  logic [15:0] switch_in,
   output logic [15:0] led_out,
   output logic        timer_irq
);

   // MMIO register offsets as word indices (addr[15:2])
   localparam logic [13:0] W_LED     = 14'h3c00;
   localparam logic [13:0] W_SWITCH  = 14'h3c08;
   localparam logic [13:0] W_SCRATCH = 14'h3c0c;
   localparam logic [13:0] W_TIMER   = 14'h3800;
   localparam logic [13:0] W_COMPARE = 14'h3801;
   localparam logic [13:0] W_CTRL    = 14'h3802;
   localparam logic [13:0] W_STATUS  = 14'h3803;

   logic [31:0] ram [2**AW];

   logic [31:0] timer;
   logic [31:0] compare;
   logic [31:0] scratch;
   logic        cmp_en;
   logic [15:0] led_reg;

   logic        is_mmio;
   logic [13:0] reg_word;
   logic [AW-1:0] word_idx;
   logic        rd_req;
   logic        ram_wr;
   logic        mmio_wr;
   logic        irq_set;
   logic [31:0] mmio_rdata;

   assign is_mmio  = (sram_addr[31:16] == MMIO_BASE);
   assign reg_word = sram_addr[15:2];
   assign word_idx = sram_addr[AW+1:2];
   assign rd_req   = sram_en && (sram_we == 4'h0);
   assign ram_wr   = sram_en && !is_mmio && (sram_we != 4'h0);
   assign mmio_wr  = sram_en && is_mmio && (sram_we == 4'hf);
   assign irq_set  = cmp_en && (timer == compare);

   assign led_out   = led_reg;

   always_comb begin
      mmio_rdata = 32'h0;
      case (reg_word)
         W_LED:     mmio_rdata = {16'h0, led_reg};
         W_SWITCH:  mmio_rdata = {16'h0, switch_in};
         W_SCRATCH: mmio_rdata = scratch;
         W_TIMER:   mmio_rdata = timer;
         W_COMPARE: mmio_rdata = compare;
         W_CTRL:    mmio_rdata = {31'h0, cmp_en};
         W_STATUS:  mmio_rdata = {31'h0, timer_irq};
         default:   mmio_rdata = 32'h0;
      endcase
   end

   // RAM is never reset; each byte lane is written independently
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ram_wr && sram_we[i]) begin
            ram[word_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sram_rdata <= 32'h0;
      end else if (rd_req) begin
         sram_rdata <= is_mmio ? mmio_rdata : ram[word_idx];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         timer     <= 32'h0;
         compare   <= 32'hffff_ffff;
         cmp_en    <= 1'b0;
         led_reg   <= 16'h0;
         scratch   <= 32'h0;
         timer_irq <= 1'b0;
      end else begin
         // A software load of TIMER overrides that cycle's increment
         if (mmio_wr && reg_word == W_TIMER) timer <= sram_wdata;
         else                                timer <= timer + 32'd1;

         if (mmio_wr && reg_word == W_COMPARE) compare <= sram_wdata;
         if (mmio_wr && reg_word == W_CTRL)    cmp_en  <= sram_wdata[0];
         if (mmio_wr && reg_word == W_LED)     led_reg <= sram_wdata[15:0];
         if (mmio_wr && reg_word == W_SCRATCH) scratch <= sram_wdata;

         // A match in the same cycle as a STATUS write keeps the interrupt pending
         if (irq_set)                                timer_irq <= 1'b1;
         else if (mmio_wr && reg_word == W_STATUS)   timer_irq <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - self-checking bench for data_sram_responder with reference model
module tb_data_sram_responder;

   logic        clk;
   logic        resetn;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic [15:0] switch_in;
   logic [15:0] led_out;
   logic        timer_irq;

   int n_vec = 0;
   int n_err = 0;
   logic chk_on = 1'b0;

   data_sram_responder #(.AW(12), .MMIO_BASE(16'hbfaf)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .switch_in  (switch_in),
      .led_out    (led_out),
      .timer_irq  (timer_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: memory map semantics as plain state
   logic [31:0] m_ram [0:4095];
   logic [31:0] m_rdata, m_timer, m_cmp, m_scratch;
   logic [15:0] m_led;
   logic        m_cmp_en, m_irq;

   function automatic logic [31:0] m_read(input logic [31:0] a);
      if (a[31:16] != 16'hbfaf) return m_ram[int'(a[13:2])];
      case (a[15:0])
         16'hf000: return {16'h0, m_led};
         16'hf020: return {16'h0, switch_in};
         16'hf030: return m_scratch;
         16'he000: return m_timer;
         16'he004: return m_cmp;
         16'he008: return {31'h0, m_cmp_en};
         16'he00c: return {31'h0, m_irq};
         default:  return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_rdata <= 32'h0; m_led <= 16'h0; m_timer <= 32'h0; m_cmp <= 32'hffff_ffff;
         m_cmp_en <= 1'b0; m_irq <= 1'b0; m_scratch <= 32'h0;
      end else begin
         m_timer <= m_timer + 32'd1;
         if (m_cmp_en && m_timer == m_cmp) m_irq <= 1'b1;
         else if (sram_en && sram_we == 4'hf && sram_addr == 32'hbfaf_e00c) m_irq <= 1'b0;
         if (sram_en && sram_we == 4'h0) m_rdata <= m_read(sram_addr);
         if (sram_en && sram_we != 4'h0) begin
            if (sram_addr[31:16] == 16'hbfaf) begin
               if (sram_we == 4'hf) begin
                  case (sram_addr[15:0])
                     16'hf000: m_led     <= sram_wdata[15:0];
                     16'he000: m_timer   <= sram_wdata;
                     16'he004: m_cmp     <= sram_wdata;
                     16'he008: m_cmp_en  <= sram_wdata[0];
                     16'hf030: m_scratch <= sram_wdata;
                     default: ;
                  endcase
               end
            end else begin
               m_ram[int'(sram_addr[13:2])] <= merge(m_ram[int'(sram_addr[13:2])], sram_wdata, sram_we);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("model_rdata", sram_rdata, m_rdata);
         check("model_led", {16'h0, led_out}, {16'h0, m_led});
         check("model_irq", {31'h0, timer_irq}, {31'h0, m_irq});
      end
   end

   task automatic req(input logic en, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
      sram_en = en; sram_we = we; sram_addr = a; sram_wdata = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) req(1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   initial begin
      resetn = 1'b0; sram_en = 1'b0; sram_we = 4'h0; sram_addr = 32'h0; sram_wdata = 32'h0;
      switch_in = 16'h0;
      @(posedge clk); #1;
      chk_on = 1'b1;
      idle(1);
      check("reset_rdata", sram_rdata, 32'h0);
      check("reset_led", {16'h0, led_out}, 32'h0);
      check("reset_irq", {31'h0, timer_irq}, 32'h0);
      resetn = 1'b1;

      req(1'b1, 4'hf, 32'h0000_0010, 32'hdead_beef);
      req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
      check("ram_read", sram_rdata, 32'hdead_beef);
      idle(2);
      check("rdata_hold", sram_rdata, 32'hdead_beef);
      req(1'b1, 4'h3, 32'h0000_0040, 32'h5555_5555);
      check("rdata_hold_on_write", sram_rdata, 32'hdead_beef);

      req(1'b1, 4'hf, 32'h0000_0020, 32'h1122_3344);
      req(1'b1, 4'h5, 32'h0000_0020, 32'haabb_ccdd);
      req(1'b1, 4'h0, 32'h0000_0020, 32'h0);
      check("byte_merge", sram_rdata, 32'h11bb_33dd);
      req(1'b1, 4'h0, 32'h0000_4020, 32'h0);
      check("ram_alias", sram_rdata, 32'h11bb_33dd);

      req(1'b1, 4'hf, 32'hbfaf_f000, 32'h0000_a5a5);
      check("led_write", {16'h0, led_out}, 32'h0000_a5a5);
      req(1'b1, 4'h3, 32'hbfaf_f000, 32'h0);
      check("led_partial_ignored", {16'h0, led_out}, 32'h0000_a5a5);
      switch_in = 16'h0f0f;
      req(1'b1, 4'h0, 32'hbfaf_f020, 32'h0);
      check("switch_read", sram_rdata, 32'h0000_0f0f);
      req(1'b1, 4'h0, 32'hbfaf_f100, 32'h0);
      check("unmapped_read", sram_rdata, 32'h0);
      req(1'b1, 4'hf, 32'hbfaf_f030, 32'h1234_5678);
      req(1'b1, 4'h0, 32'hbfaf_f030, 32'h0);
      check("scratch_read", sram_rdata, 32'h1234_5678);

      req(1'b1, 4'hf, 32'hbfaf_e000, 32'd100);
      req(1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
      check("timer_load_read", sram_rdata, 32'd100);
      req(1'b1, 4'hf, 32'hbfaf_e000, 32'hffff_fffe);
      idle(2);
      req(1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
      check("timer_wrap", sram_rdata, 32'h0);

      req(1'b1, 4'hf, 32'hbfaf_e004, 32'd50);
      req(1'b1, 4'hf, 32'hbfaf_e008, 32'd1);
      req(1'b1, 4'hf, 32'hbfaf_e000, 32'd45);
      idle(5);
      check("irq_before_match", {31'h0, timer_irq}, 32'h0);
      idle(1);
      check("irq_after_match", {31'h0, timer_irq}, 32'h1);
      idle(3);
      check("irq_sticky", {31'h0, timer_irq}, 32'h1);
      req(1'b1, 4'h0, 32'hbfaf_e00c, 32'h0);
      check("status_read", sram_rdata, 32'h1);
      req(1'b1, 4'hf, 32'hbfaf_e00c, 32'h0);
      check("irq_clear", {31'h0, timer_irq}, 32'h0);
      req(1'b1, 4'hf, 32'hbfaf_e000, 32'd45);
      idle(5);
      req(1'b1, 4'hf, 32'hbfaf_e00c, 32'h0);
      check("irq_set_wins", {31'h0, timer_irq}, 32'h1);

      req(1'b1, 4'hf, 32'hbfaf_f000, 32'h0000_ffff);
      check("led_ffff", {16'h0, led_out}, 32'h0000_ffff);
      sram_en = 1'b1; sram_we = 4'h0; sram_addr = 32'h0000_0010;
      #2;
      resetn = 1'b0;
      #1;
      check("async_led", {16'h0, led_out}, 32'h0);
      check("async_irq", {31'h0, timer_irq}, 32'h0);
      check("async_rdata", sram_rdata, 32'h0);
      @(posedge clk); #1;
      check("pending_read_dropped", sram_rdata, 32'h0);
      resetn = 1'b1;
      req(1'b1, 4'h0, 32'h0000_0010, 32'h0);
      check("ram_survives_reset", sram_rdata, 32'hdead_beef);
      idle(2);

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
Responder (slave) end of the CPU data SRAM interface. It services en/we/addr/wdata requests from the pipeline's memory-access stage, with read data returned on rdata one cycle later. The address space is split into a word-addressed local RAM and a small MMIO register window: LED, switch, free-running timer, timer compare, IRQ status and scratch. It sits beside the CPU top in the SoC wrapper and drives the board LEDs and a timer interrupt line.

Parameters:
AW, 12, RAM word-address width; RAM depth = 2^AW 32-bit words.
MMIO_BASE, 16'hbfaf, value of addr[31:16] that selects the MMIO window.

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
sram_en  input  1  request valid this cycle
sram_we  input  4  byte write enables; 4'h0 = read
sram_addr  input  32  byte address; addr[1:0] ignored
sram_wdata  input  32  write data, byte lane i = wdata[8i+7:8i]
sram_rdata  output  32  read data, valid the cycle after a read request
switch_in  input  16  board switch levels, sampled on read
led_out  output  16  LED register value
timer_irq  output  1  sticky timer-match interrupt

Behaviour:
- Reset (resetn low, async): sram_rdata=0, led_out=0, timer=0, compare=32'hffff_ffff, cmp_en=0, timer_irq=0, scratch=0. RAM contents are not reset.
- Decode: MMIO when addr[31:16]==MMIO_BASE; otherwise RAM at word index addr[AW+1:2], with upper bits aliased.
- MMIO offsets (addr[15:0]):
  - f000 LED: RW, bits[15:0]; reads zero-extend.
  - f020 SWITCH: RO, returns {16'b0, switch_in}.
  - e000 TIMER: RW.
  - e004 COMPARE: RW.
  - e008 CTRL: RW, bit0 = cmp_en.
  - e00c STATUS: read returns {31'b0, timer_irq}; any write clears irq.
  - f030 SCRATCH: RW.
  - Other offsets: reads return 0, writes are ignored.
- Read (en=1, we=0): sram_rdata is updated at the next edge with the addressed value. Latency is exactly 1 cycle.
- sram_rdata holds its last value in every cycle without a read request (en=0, or en=1 with we!=0).
- RAM write: per-byte, only lanes with we[i]=1 change.
- MMIO write: takes effect only when we==4'hf; partial-byte MMIO writes are ignored entirely.
- en=0: we, addr and wdata are don't-care; no state changes except timer and irq.
- Read-after-write to the same RAM word on consecutive cycles returns the new data. There is no same-cycle read/write; one request per cycle.
- Timer: increments by 1 every cycle, wrapping 32'hffff_ffff to 0.
  - A full-word write to TIMER loads wdata, and the written value wins over the increment that cycle.
  - A TIMER read returns the pre-increment value in the cycle of the request.
- IRQ:
  - Set condition: cmp_en=1 and the current timer value == compare. timer_irq goes high the next edge.
  - Sticky until a write to STATUS.
  - If set and clear occur in the same cycle, set wins.
  - Clearing cmp_en does not clear timer_irq.
- led_out is driven directly from the LED register; a write is visible the cycle after the request edge.
- Reset asserted mid-operation: all registers return to reset values immediately (async). A read request pending at that edge produces no rdata; rdata=0.

Test Plan:
1. Reset, then read RAM 0x0000_0010 after writing 32'hdead_beef with we=4'hf -> rdata=32'hdead_beef exactly one cycle after the read request; rdata holds through following idle cycles.
2. Write 32'h1122_3344 to RAM 0x20, then write 32'haabb_ccdd with we=4'b0101, then read 0x20 -> rdata=32'h11bb_33dd.
3. Write 32'h0000_a5a5 to 0xbfaf_f000 -> led_out=16'ha5a5 next cycle; a partial write with we=4'h3 of 0 -> led_out unchanged. Read 0xbfaf_f020 with switch_in=16'h0f0f -> rdata=32'h0000_0f0f. Read 0xbfaf_f100 -> rdata=0.
4. Write TIMER=100, then read TIMER on the cycle immediately after -> rdata=100. Write TIMER=32'hffff_fffe and wait 2 cycles -> timer=0, confirming wrap-around.
5. COMPARE=50, CTRL=1, TIMER=45 -> timer_irq rises on the edge after timer==50 and stays high. Write STATUS -> irq=0. Re-arm so a STATUS write lands on the match cycle -> irq remains 1 (set wins).
6. Assert resetn low mid-stream with led=16'hffff and irq=1 -> led_out=0, timer_irq=0, rdata=0 asynchronously. After release, a RAM read returns data written before reset.
